// File: rtl/fir_pkg.sv
// Shared types and constants for the FIR MAC sequencer: FSM states, default
// geometry and the accumulator-width helper.
package fir_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StMac,
    StOut
  } fir_state_e;

  localparam int unsigned DefaultN     = 21;
  localparam int unsigned DefaultWidth = 16;

  // Enough headroom to sum n full-precision products without overflow.
  function automatic int unsigned acc_width(input int unsigned width, input int unsigned n);
    return 2 * width + $clog2(n);
  endfunction

endpackage

// File: rtl/fir_mac.sv
// Shared signed multiplier and accumulator; one product is added per enabled cycle.
module fir_mac #(
  parameter int unsigned Width = 16,
  parameter int unsigned AccW  = 37
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic                    en,
  input  logic signed [Width-1:0] a,
  input  logic signed [Width-1:0] b,
  output logic signed [AccW-1:0]  acc
);

  logic signed [2*Width-1:0] prod;
  logic signed [AccW-1:0]    acc_d, acc_q;

  assign prod = a * b;

  always_comb begin
    acc_d = acc_q;
    if (clr) begin
      acc_d = '0;
    end else if (en) begin
      acc_d = acc_q + {{(AccW-2*Width){prod[2*Width-1]}}, prod};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc = acc_q;

endmodule

// File: rtl/fir_mac_sequencer.sv
// Time-multiplexed N-tap FIR: one tap per cycle through a single MAC.
// Define FIR_SAT_EN to saturate the output instead of wrapping it.
module fir_mac_sequencer
  import fir_pkg::*;
#(
  parameter int unsigned N     = DefaultN,
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic signed [WIDTH-1:0] s_data,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic signed [WIDTH-1:0] m_data,
  input  logic                    coef_we,
  input  logic [$clog2(N)-1:0]    coef_addr,
  input  logic signed [WIDTH-1:0] coef_wdata,
  output logic                    busy
);

  localparam int unsigned     AddrW   = $clog2(N);
  localparam int unsigned     AccW    = acc_width(WIDTH, N);
  localparam logic [AddrW-1:0] LastTap = AddrW'(N - 1);
  localparam logic [AddrW:0]   NExt    = (AddrW + 1)'(N);

  fir_state_e state_d, state_q;
  logic [AddrW-1:0] tap_d, tap_q;
  logic [AddrW-1:0] wr_ptr_d, wr_ptr_q;
  logic signed [WIDTH-1:0] ring_q [N];
  logic signed [WIDTH-1:0] coef_q [N];

  logic                   mac_clr, mac_en, accept, coef_wr;
  logic [AddrW:0]         rd_sum;
  logic [AddrW-1:0]       rd_idx;
  logic signed [AccW-1:0] acc, shifted;

  assign accept  = (state_q == StIdle) && s_valid;
  assign coef_wr = (state_q == StIdle) && coef_we && (coef_addr <= LastTap);
  assign busy    = (state_q != StIdle);

  // Ring read index (wr_ptr - tap) mod N without a divider.
  always_comb begin
    rd_sum = {1'b0, wr_ptr_q} + NExt - {1'b0, tap_q};
    rd_idx = (rd_sum >= NExt) ? AddrW'(rd_sum - NExt) : AddrW'(rd_sum);
  end

  always_comb begin
    state_d  = state_q;
    tap_d    = tap_q;
    wr_ptr_d = wr_ptr_q;
    mac_clr  = 1'b0;
    mac_en   = 1'b0;
    s_ready  = 1'b0;
    m_valid  = 1'b0;
    unique case (state_q)
      StIdle: begin
        s_ready = 1'b1;
        if (s_valid) begin
          mac_clr = 1'b1;
          tap_d   = '0;
          state_d = StMac;
        end
      end
      StMac: begin
        mac_en = 1'b1;
        if (tap_q == LastTap) begin
          tap_d   = '0;
          state_d = StOut;
        end else begin
          tap_d = tap_q + 1'b1;
        end
      end
      StOut: begin
        m_valid = 1'b1;
        if (m_ready) begin
          wr_ptr_d = (wr_ptr_q == LastTap) ? '0 : wr_ptr_q + 1'b1;
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      tap_q    <= '0;
      wr_ptr_q <= '0;
      for (int i = 0; i < int'(N); i++) begin
        ring_q[i] <= '0;
        coef_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      tap_q    <= tap_d;
      wr_ptr_q <= wr_ptr_d;
      if (accept) begin
        ring_q[wr_ptr_q] <= s_data;
      end
      if (coef_wr) begin
        coef_q[coef_addr] <= coef_wdata;
      end
    end
  end

  fir_mac #(
    .Width(WIDTH),
    .AccW (AccW)
  ) u_fir_mac (
    .clk(clk),
    .rst(rst),
    .clr(mac_clr),
    .en (mac_en),
    .a  (ring_q[rd_idx]),
    .b  (coef_q[tap_q]),
    .acc(acc)
  );

  // Arithmetic shift floors toward minus infinity; acc is frozen outside MAC.
  assign shifted = acc >>> (WIDTH - 1);

`ifdef FIR_SAT_EN
  localparam logic signed [AccW-1:0] SatMax = {{(AccW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [AccW-1:0] SatMin = {{(AccW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};
  always_comb begin
    m_data = shifted[WIDTH-1:0];
    if (shifted > SatMax) begin
      m_data = {1'b0, {(WIDTH-1){1'b1}}};
    end else if (shifted < SatMin) begin
      m_data = {1'b1, {(WIDTH-1){1'b0}}};
    end
  end
`else
  assign m_data = shifted[WIDTH-1:0];
`endif

endmodule
